// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Start/busy/done handshake plus operand and HI/LO result bus of the multiplier.
interface mul_seq_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, signed_op, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, signed_op, A, B,
    output busy, done, HI, LO
  );

endinterface

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier with MIPS MULT/MULTU style HI/LO result.
// Signed operands are reduced to magnitudes, multiplied unsigned over WIDTH
// steps, and the sign is reapplied on the full-width product in FIN.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);

  mul_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   mcand_r;
  logic               neg_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] fin_s;

  // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // One add/shift step and the sign-corrected final product.
  always_comb begin
    addend_s = {(WIDTH+1){1'b0}};
    if (mplier_r[0]) begin
      addend_s = {1'b0, mcand_r};
    end else begin
      addend_s = {(WIDTH+1){1'b0}};
    end
    sum_s  = {1'b0, acc_hi_r} + addend_s;
    prod_s = {acc_hi_r, mplier_r};
    if (neg_r) begin
      fin_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      fin_s = prod_s;
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r  <= RUN;
            busy_r   <= 1'b1;
            mcand_r  <= mag(bus.A, bus.signed_op);
            mplier_r <= mag(bus.B, bus.signed_op);
            neg_r    <= bus.signed_op & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            acc_hi_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          // Shift {carry, acc_hi, mplier} right by one after the conditional add.
          acc_hi_r <= sum_s[WIDTH:1];
          mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= FIN;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FIN: begin
          hi_r    <= fin_s[2*WIDTH-1:WIDTH];
          lo_r    <= fin_s[WIDTH-1:0];
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: an arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed products.
module tb_mul_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  mul_seq_if #(.WIDTH(W)) mif ();

  mul_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  always #5 clk = ~clk;

  // Reference model state: in-flight flag, edges until done, pending/held result.
  logic          busy_m = 1'b0;
  logic          done_m = 1'b0;
  int            left_m = 0;
  logic [2*W-1:0] pend_m = '0;
  logic [2*W-1:0] res_m = '0;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
    int ia;
    int ib;
    int p;
    if (s) begin
      ia = $signed(a);
      ib = $signed(b);
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    p = ia * ib;
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accept when idle, finish WIDTH+1 edges later, reset clears everything.
  always @(posedge clk) begin
    if (rst) begin
      busy_m <= 1'b0;
      done_m <= 1'b0;
      left_m <= 0;
      res_m  <= '0;
    end else begin
      done_m <= 1'b0;
      if (busy_m) begin
        if (left_m == 1) begin
          busy_m <= 1'b0;
          done_m <= 1'b1;
          res_m  <= pend_m;
          left_m <= 0;
        end else begin
          left_m <= left_m - 1;
        end
      end else if (mif.start) begin
        busy_m <= 1'b1;
        left_m <= W + 1;
        pend_m <= ref_prod(mif.A, mif.B, mif.signed_op);
      end
    end
  end

  // Every-cycle compare of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_busy", {31'd0, mif.busy}, {31'd0, busy_m});
      chk("model_done", {31'd0, mif.done}, {31'd0, done_m});
      chk("model_hilo", {16'd0, mif.HI, mif.LO}, {16'd0, res_m});
    end
  end

  // Drive a start for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    mif.A         = a;
    mif.B         = b;
    mif.signed_op = s;
    mif.start     = 1'b1;
    @(negedge clk);
    mif.start     = 1'b0;
  endtask

  // Wait for done, checking latency, busy cycles, held value and product.
  task automatic wait_done(input string name, input logic [2*W-1:0] exp,
                           input logic [2*W-1:0] hold, input int lat_exp);
    int lat;
    int busy_cnt;
    bit seen;
    lat = 0;
    seen = 1'b0;
    busy_cnt = (mif.busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (mif.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (mif.busy === 1'b1) busy_cnt++;
      chk({name, "_hold"}, {16'd0, mif.HI, mif.LO}, {16'd0, hold});
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end else begin
      chk({name, "_lat"}, lat, lat_exp);
      chk({name, "_busy"}, busy_cnt, lat_exp);
      chk({name, "_prod"}, {16'd0, mif.HI, mif.LO}, {16'd0, exp});
      chk({name, "_model"}, {16'd0, res_m}, {16'd0, exp});
    end
  endtask

  initial begin
    int dcount;
    mif.start     = 1'b0;
    mif.signed_op = 1'b0;
    mif.A         = '0;
    mif.B         = '0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, mif.busy}, 32'd0);
    chk("rst_done", {31'd0, mif.done}, 32'd0);
    chk("rst_hilo", {16'd0, mif.HI, mif.LO}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'hFF, 8'hFF, 1'b0); wait_done("u_max",     16'hFE01, 16'h0000, 9);
    issue(8'hFF, 8'h7F, 1'b1); wait_done("s_m1x127",  16'hFF81, 16'hFE01, 9);
    issue(8'h80, 8'h80, 1'b1); wait_done("s_minmin",  16'h4000, 16'hFF81, 9);
    issue(8'h80, 8'h01, 1'b1); wait_done("s_minx1",   16'hFF80, 16'h4000, 9);
    issue(8'h00, 8'hA5, 1'b0); wait_done("u_zero",    16'h0000, 16'hFF80, 9);
    issue(8'h01, 8'h80, 1'b0); wait_done("u_1x80",    16'h0080, 16'h0000, 9);
    issue(8'h00, 8'hA5, 1'b1); wait_done("s_zero",    16'h0000, 16'h0080, 9);
    issue(8'h01, 8'h80, 1'b1); wait_done("s_1x80",    16'hFF80, 16'h0000, 9);

    // Start while busy: second request and operand changes must be ignored.
    issue(8'd3, 8'd5, 1'b0);
    repeat (2) @(negedge clk);
    issue(8'd7, 8'd7, 1'b1);
    wait_done("busy_ign", 16'h000F, 16'hFF80, 6);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mif.done === 1'b1) dcount++;
    end
    chk("busy_ign_no2nd", dcount, 0);

    // Back-to-back: new start driven in the done cycle.
    issue(8'd3, 8'd5, 1'b0);
    wait_done("b2b_first", 16'h000F, 16'h000F, 9);
    issue(8'h10, 8'h10, 1'b0);
    chk("b2b_done_drop", {31'd0, mif.done}, 32'd0);
    wait_done("b2b_second", 16'h0100, 16'h000F, 9);

    // Reset in the middle of RUN aborts the operation.
    issue(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, mif.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, mif.done}, 32'd0);
    chk("mid_rst_hilo", {16'd0, mif.HI, mif.LO}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mif.done === 1'b1) dcount++;
    end
    chk("mid_rst_nodone", dcount, 0);
    issue(8'h0C, 8'h0D, 1'b0); wait_done("after_rst", 16'h009C, 16'h0000, 9);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
